wb_dbg_master: RTL and testbench

- Wishbone initiator driven by a byte stream: a host-side debug link that reads and writes any slave on the SoC bus.
- Sits on a spare master port of the Wishbone interconnect.
- Bytes come from a UART receiver and responses go to a UART transmitter; both are plain byte handshakes.
- Gives a debugger bus access independent of the lm32 core.

---
 rtl/wb_dbg_master.sv | 161 ++++++++++++++++
 tb/tb_wb_dbg_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dbg_master.sv
// rtl/wb_dbg_master.sv - byte-stream driven Wishbone debug initiator
// Optional WB_DBG_ADDR_INC_EN adds 'w'/'r' commands on the stored address pre-incremented by 4.
module wb_dbg_master #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_stb,
  output logic [7:0]  tx_data,
  output logic        tx_stb,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_BUS    = 3'd3;
  localparam logic [2:0] S_STATUS = 3'd4;
  localparam logic [2:0] S_RDATA  = 3'd5;

  localparam logic [15:0] TIMER_LAST = 16'(timeout_cycles - 1);

  logic [2:0]  state;
  logic [1:0]  cnt;
  logic [15:0] timer;
  logic        bus_err;
  logic        tx_wait;
  logic [31:0] rdata;
  logic [7:0]  tx_byte;

  assign wb_sel_o = 4'hF;

  always_comb begin
    tx_byte = rdata[31:24];
    if (state == S_STATUS) tx_byte = bus_err ? 8'h15 : 8'h06;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      timer    <= 16'd0;
      bus_err  <= 1'b0;
      tx_wait  <= 1'b0;
      rdata    <= 32'd0;
      tx_data  <= 8'd0;
      tx_stb   <= 1'b0;
      wb_adr_o <= 32'd0;
      wb_dat_o <= 32'd0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt   <= 2'd0;
          timer <= 16'd0;
          if (rx_stb) begin
            case (rx_data)
              8'h57: begin wb_we_o <= 1'b1; state <= S_ADDR; end
              8'h52: begin wb_we_o <= 1'b0; state <= S_ADDR; end
`ifdef WB_DBG_ADDR_INC_EN
              8'h77: begin
                wb_we_o  <= 1'b1;
                wb_adr_o <= wb_adr_o + 32'd4;
                state    <= S_DATA;
              end
              8'h72: begin
                wb_we_o  <= 1'b0;
                wb_adr_o <= wb_adr_o + 32'd4;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                state    <= S_BUS;
              end
`endif
              default: ;
            endcase
          end
        end
        S_ADDR: begin
          if (rx_stb) begin
            wb_adr_o <= {wb_adr_o[23:0], rx_data};
            cnt      <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (wb_we_o) begin
                state <= S_DATA;
              end else begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                state    <= S_BUS;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_stb) begin
            wb_dat_o <= {wb_dat_o[23:0], rx_data};
            cnt      <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              state    <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // Any err/rty wins over a simultaneous ack.
          if (wb_ack_i || wb_err_i || wb_rty_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            bus_err  <= wb_err_i || wb_rty_i;
            if (!(wb_err_i || wb_rty_i)) rdata <= wb_dat_i;
            state    <= S_STATUS;
          end else if (timer == TIMER_LAST) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            bus_err  <= 1'b1;
            state    <= S_STATUS;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_STATUS, S_RDATA: begin
          // One strobe per byte, then wait out the transmitter's busy period.
          if (tx_stb) begin
            tx_stb  <= 1'b0;
            tx_wait <= 1'b1;
          end else if (tx_wait) begin
            if (!tx_busy) begin
              tx_wait <= 1'b0;
              if (state == S_STATUS) begin
                cnt   <= 2'd0;
                state <= (bus_err || wb_we_o) ? S_IDLE : S_RDATA;
              end else begin
                rdata <= {rdata[23:0], 8'h00};
                cnt   <= cnt + 2'd1;
                if (cnt == 2'd3) state <= S_IDLE;
              end
            end
          end else if (!tx_busy) begin
            tx_stb  <= 1'b1;
            tx_data <= tx_byte;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dbg_master.sv
// tb/tb_wb_dbg_master.sv - table-driven scoreboard bench for wb_dbg_master
// Expectations for 'w'/'r' follow WB_DBG_ADDR_INC_EN.
module tb_wb_dbg_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_stb = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_stb;
  logic        tx_busy;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  always #5 clk = ~clk;

  wb_dbg_master #(.timeout_cycles(255)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_busy(tx_busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          dur;
  } bus_t;

  typedef struct {
    int               n;
    logic [0:8][7:0]  b;
    int               mode;
    int               dly;
    logic [31:0]      rd;
    int               nbus;
    bus_t             bus;
    int               ntx;
    logic [0:4][7:0]  tx;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bus_t bq[$];
  logic [7:0] tq[$];
  int cyc_starts = 0;

  // slave modes: 0 ack, 1 err, 2 rty, 3 silent, 4 ack+err together
  int s_mode = 3;
  int s_dly = 0;
  logic [31:0] s_rd = 32'h0;
  int cyc_cnt = 0;
  int busy_cnt = 0;

  always @(posedge clk) cyc_cnt <= (wb_cyc_o && wb_stb_o) ? cyc_cnt + 1 : 0;
  wire hit = wb_cyc_o && wb_stb_o && (cyc_cnt == s_dly);
  assign wb_ack_i = hit && (s_mode == 0 || s_mode == 4);
  assign wb_err_i = hit && (s_mode == 1 || s_mode == 4);
  assign wb_rty_i = hit && (s_mode == 2);
  assign wb_dat_i = wb_ack_i ? s_rd : 32'h0;

  always @(posedge clk) begin
    if (!reset_n) busy_cnt <= 0;
    else if (tx_stb) busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  bus_t cur;
  int dur = 0;
  logic prev_cyc = 1'b0;
  logic prev_tx = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (wb_cyc_o && !prev_cyc) begin
        cyc_starts++;
        if (bq.size() == 0) begin
          chk("unexpected_bus_cycle", wb_adr_o, 32'hFFFF_FFFF);
          cur = '{wb_adr_o, wb_dat_o, wb_we_o, 0};
        end else begin
          cur = bq.pop_front();
          chk("bus_adr", wb_adr_o, cur.adr);
          chk("bus_we", {31'd0, wb_we_o}, {31'd0, cur.we});
          chk("bus_stb", {31'd0, wb_stb_o}, 32'd1);
          chk("bus_sel", {28'd0, wb_sel_o}, 32'hF);
          if (cur.we) chk("bus_dat", wb_dat_o, cur.dat);
        end
        dur = 1;
      end else if (wb_cyc_o) begin
        dur++;
      end else if (prev_cyc && cur.dur != 0) begin
        chk("bus_duration", dur, cur.dur);
        chk("bus_adr_held", wb_adr_o, cur.adr);
      end
      if (tx_stb) begin
        chk("tx_while_busy", {31'd0, tx_busy}, 32'd0);
        chk("tx_stb_width", {31'd0, prev_tx}, 32'd0);
        if (tq.size() == 0) chk("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'd0, tx_data}, {24'd0, tq.pop_front()});
      end
    end
    prev_cyc = wb_cyc_o;
    prev_tx = tx_stb;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((bq.size() != 0 || tq.size() != 0 || wb_cyc_o || tx_busy) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk("wait_idle_timeout", k, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    s_mode = v.mode;
    s_dly = v.dly;
    s_rd = v.rd;
    if (v.nbus != 0) bq.push_back(v.bus);
    for (int i = 0; i < v.ntx; i++) tq.push_back(v.tx[i]);
    for (int i = 0; i < v.n; i++) send_byte(v.b[i]);
    wait_idle();
  endtask

  vec_t vt[7];
  vec_t v;
  int starts0;

  initial begin
    vt[0] = '{9, {8'h57,8'h00,8'h00,8'h70,8'h00,8'h00,8'h00,8'h00,8'h41}, 0, 2, 32'h0,
              1, '{32'h0000_7000, 32'h0000_0041, 1'b1, 3}, 1, {8'h06,8'h00,8'h00,8'h00,8'h00}};
    vt[1] = '{5, {8'h52,8'h40,8'h00,8'h00,8'h10,8'h00,8'h00,8'h00,8'h00}, 0, 0, 32'hDEAD_BEEF,
              1, '{32'h4000_0010, 32'h0, 1'b0, 1}, 5, {8'h06,8'hDE,8'hAD,8'hBE,8'hEF}};
    vt[2] = '{5, {8'h52,8'h00,8'h00,8'h00,8'h20,8'h00,8'h00,8'h00,8'h00}, 3, 0, 32'h0,
              1, '{32'h0000_0020, 32'h0, 1'b0, 255}, 1, {8'h15,8'h00,8'h00,8'h00,8'h00}};
    vt[3] = '{5, {8'h52,8'h00,8'h00,8'h00,8'h24,8'h00,8'h00,8'h00,8'h00}, 1, 3, 32'h1111_1111,
              1, '{32'h0000_0024, 32'h0, 1'b0, 4}, 1, {8'h15,8'h00,8'h00,8'h00,8'h00}};
    vt[4] = '{8, {8'h00,8'hFF,8'h41,8'h52,8'h12,8'h34,8'h56,8'h78,8'h00}, 0, 1, 32'h0BAD_F00D,
              1, '{32'h1234_5678, 32'h0, 1'b0, 2}, 5, {8'h06,8'h0B,8'hAD,8'hF0,8'h0D}};
    vt[5] = '{9, {8'h57,8'h00,8'h00,8'h00,8'h04,8'h11,8'h22,8'h33,8'h44}, 2, 1, 32'h0,
              1, '{32'h0000_0004, 32'h1122_3344, 1'b1, 2}, 1, {8'h15,8'h00,8'h00,8'h00,8'h00}};
    vt[6] = '{5, {8'h52,8'h00,8'h00,8'h00,8'h08,8'h00,8'h00,8'h00,8'h00}, 4, 0, 32'h5555_5555,
              1, '{32'h0000_0008, 32'h0, 1'b0, 1}, 1, {8'h15,8'h00,8'h00,8'h00,8'h00}};

    repeat (3) @(negedge clk);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_ctl", {28'd0, wb_cyc_o, wb_stb_o, wb_we_o, tx_stb}, 32'h0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'hF);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // rx bytes arriving during BUS/STATUS/RDATA are dropped
    s_mode = 0; s_dly = 12; s_rd = 32'h1357_9BDF;
    bq.push_back('{32'h0000_00A0, 32'h0, 1'b0, 13});
    tq.push_back(8'h06); tq.push_back(8'h13); tq.push_back(8'h57);
    tq.push_back(8'h9B); tq.push_back(8'hDF);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hA0);
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_idle();
    chk("extra_rx_one_cycle_pending", bq.size(), 0);

    // reset in the middle of a write bus cycle
    s_mode = 3;
    bq.push_back('{32'h0000_1234, 32'h0000_CAFE, 1'b1, 0});
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hCA); send_byte(8'hFE);
    begin
      int k = 0;
      while (!wb_cyc_o && k < 50) begin @(negedge clk); k++; end
      chk("midrst_cyc_seen", {31'd0, wb_cyc_o}, 32'd1);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ctl", {29'd0, wb_cyc_o, wb_stb_o, tx_stb}, 32'h0);
    chk("midrst_adr", wb_adr_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    v = vt[0];
    v.b = {8'h57,8'h00,8'h00,8'h00,8'h30,8'hA5,8'h5A,8'h00,8'hFF};
    v.bus = '{32'h0000_0030, 32'hA55A_00FF, 1'b1, 3};
    run_vec(v);

`ifdef WB_DBG_ADDR_INC_EN
    v = vt[1];
    v.b = {8'h52,8'h00,8'h00,8'hFF,8'hFC,8'h00,8'h00,8'h00,8'h00};
    v.bus.adr = 32'h0000_FFFC;
    run_vec(v);
    v.n = 1;
    v.b = {8'h72,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    v.bus.adr = 32'h0001_0000;
    run_vec(v);
    v.bus.adr = 32'h0001_0004;
    run_vec(v);
`else
    starts0 = cyc_starts;
    send_byte(8'h72);
    send_byte(8'h77);
    repeat (20) @(negedge clk);
    chk("inc_cmd_ignored", cyc_starts, starts0);
`endif

    chk("bus_queue_empty", bq.size(), 0);
    chk("tx_queue_empty", tq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
